// File: rtl/prbs_chk_if.sv
// prbs_chk_if -- signal bundle between a PRBS checker and its environment.
//
// Signals:
//   c          8   feedback tap mask (bit i set = state bit i feeds the XOR)
//   din        1   received serial sequence bit
//   din_valid  1   din is sampled only while this is high
//   clr_cnt    1   synchronous clear of err_cnt
//   locked     1   checker is tracking the sequence
//   err_pulse  1   one-cycle flag for a mismatched bit
//   err_cnt   16   saturating mismatch count since reset or clear
//
// Modports:
//   master  -- the environment: drives c/din/din_valid/clr_cnt, observes status
//   slave   -- the checker: consumes the inputs, drives the status outputs
interface prbs_chk_if;
    logic [7:0]  c;
    logic        din;
    logic        din_valid;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;

    modport master (
        output c,
        output din,
        output din_valid,
        output clr_cnt,
        input  locked,
        input  err_pulse,
        input  err_cnt
    );

    modport slave (
        input  c,
        input  din,
        input  din_valid,
        input  clr_cnt,
        output locked,
        output err_pulse,
        output err_cnt
    );
endinterface

// File: rtl/prbs_chk.sv
// prbs_chk -- self-synchronising 8-bit PRBS checker.
//
// The sequence is the team generator's: fb = ^(c & s), s <= {s[6:0], fb},
// transmitted bit = fb. The checker hunts for the sequence by loading eight
// received bits straight into its state, then free-runs its own copy and
// compares every valid received bit against the locally predicted bit.
//
// Parameters:
//   ERR_THRESH  errors within one window that force loss of lock (1..WINDOW)
//   WINDOW      error-monitoring window length in locked bits (2..255)
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (released synchronously upstream)
//   bus    prbs_chk_if.slave: c, din, din_valid, clr_cnt in;
//          locked, err_pulse, err_cnt out
module prbs_chk #(
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned WINDOW     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    prbs_chk_if.slave   bus
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        LOAD = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [7:0] WIN_LAST = 8'(WINDOW);
    localparam logic [7:0] THRESH   = 8'(ERR_THRESH);

    state_t      state_q, state_d;
    logic [7:0]  s_q, s_d;
    logic [2:0]  ld_cnt_q, ld_cnt_d;
    logic [7:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  werr_q, werr_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_pulse_q, err_pulse_d;

    logic        exp_bit;
    logic        mism;
    logic        err_inc;
    logic [7:0]  s_rx_shift;
    logic [7:0]  bit_inc;
    logic [7:0]  werr_inc;

    // Locally predicted bit and the received-bit shift used while loading.
    assign exp_bit    = ^(bus.c & s_q);
    assign mism       = bus.din ^ exp_bit;
    assign s_rx_shift = {s_q[6:0], bus.din};
    assign bit_inc    = bit_cnt_q + 8'd1;
    assign werr_inc   = werr_q + {7'd0, mism};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            s_q         <= '0;
            ld_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            werr_q      <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            ld_cnt_q    <= ld_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            werr_q      <= werr_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        ld_cnt_d    = ld_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        werr_d      = werr_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (bus.din_valid) begin
                    s_d      = s_rx_shift;
                    ld_cnt_d = 3'd1;
                    state_d  = LOAD;
                end
            end

            LOAD: begin
                if (bus.din_valid) begin
                    s_d = s_rx_shift;
                    if (ld_cnt_q == 3'd7) begin
                        // Eighth bit: an all-zero state would lock up the
                        // predictor, so refuse it and hunt again.
                        ld_cnt_d = '0;
                        state_d  = (s_rx_shift != 8'd0) ? LOCK : HUNT;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 3'd1;
                    end
                end
            end

            LOCK: begin
                if (bus.din_valid) begin
                    // The predictor feeds back its own bit, so a corrupted
                    // received bit never disturbs the tracked state.
                    s_d         = {s_q[6:0], exp_bit};
                    err_pulse_d = mism;
                    err_inc     = mism;
                    if (mism && (werr_inc == THRESH)) begin
                        // Loss of lock wins over a coincident window close.
                        state_d   = HUNT;
                        bit_cnt_d = '0;
                        werr_d    = '0;
                    end else if (bit_inc == WIN_LAST) begin
                        bit_cnt_d = '0;
                        werr_d    = '0;
                    end else begin
                        bit_cnt_d = bit_inc;
                        werr_d    = werr_inc;
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // Clear overrides a same-cycle increment; the count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.clr_cnt) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    assign bus.locked    = (state_q == LOCK);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: doc/prbs_chk.md
PRBS_CHK -- requirements
Module: prbs_chk

Interface
REQ-001 Parameter ERR_THRESH, default 4: errors within one window that force loss of lock (1..WINDOW).
REQ-002 Parameter WINDOW, default 16: length of the error-monitoring window in locked bits (2..255).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port c  input  8  feedback tap mask; bit i set = state bit i feeds the XOR.
REQ-006 Port din  input  1  received serial sequence bit.
REQ-007 Port din_valid  input  1  din is sampled only in cycles where this is high.
REQ-008 Port clr_cnt  input  1  synchronous clear of err_cnt.
REQ-009 Port locked  output  1  high while the checker is tracking the sequence.
REQ-010 Port err_pulse  output  1  one-cycle flag for a mismatched bit.
REQ-011 Port err_cnt  output  16  total mismatches since reset or clear.

Function
REQ-012 Sequence definition, identical to the team's generator: state s[7:0]; fb = XOR-reduce(c & s); next s = {s[6:0], fb}; the transmitted bit is fb.
REQ-013 The FSM SHALL have exactly three states: HUNT, LOAD, LOCK.
REQ-014 HUNT: on a valid bit, shift din into s, set load count to 1 and go to LOAD.
REQ-015 LOAD: each valid bit shifts din into s and increments load count; at the 8th bit, go to LOCK if the new s != 0, else go to HUNT (all-zero lockup guard).
REQ-016 locked SHALL be high in the cycle after the 8th bit is sampled, and remain high for as long as the FSM is in LOCK.
REQ-017 LOCK: on a valid bit, expected = XOR-reduce(c & s); s <= {s[6:0], expected}, so a received bit error never corrupts s.
REQ-018 LOCK: din != expected SHALL set err_pulse high for exactly the next cycle, and increment err_cnt.
REQ-019 LOCK window: a bit counter and a window-error counter both advance on valid bits; both SHALL clear after the WINDOW-th bit.
REQ-020 If a mismatch brings the window-error count to ERR_THRESH, the FSM SHALL go to HUNT.
  - locked drops in the next cycle.
  - Window counters clear.
  - This mismatch still pulses err_pulse and counts in err_cnt.
REQ-021 When the threshold-reaching error lands on the WINDOW-th bit, loss of lock SHALL take priority over the window clear.
REQ-022 err_cnt SHALL saturate at 16'hFFFF.
REQ-023 clr_cnt SHALL set err_cnt to 0 on the next edge, overriding a simultaneous increment; it SHALL NOT affect FSM state or window counters.
REQ-024 Cycles with din_valid low SHALL change nothing, except that err_pulse returns to 0 and clr_cnt still takes effect.
REQ-025 Mismatches SHALL never be counted in HUNT or LOAD.
REQ-026 c is used combinationally each cycle.
  - A change while in LOCK takes effect on the next valid bit.
  - There is no automatic relock; loss of lock occurs only via the REQ-020 threshold.
REQ-027 c = 0 SHALL be legal: expected is always 0.

Reset
REQ-028 rst_n low SHALL immediately force the following, regardless of clk:
  - FSM to HUNT;
  - s, load count, window counters and err_cnt to 0;
  - locked and err_pulse to 0.
REQ-029 Reset asserted mid-LOAD or mid-LOCK SHALL discard all progress; after release, lock needs 8 fresh valid bits.
REQ-030 Reset SHALL be released synchronously to clk by the instantiating logic.

Verification
REQ-031 Lock: c=8'hB8, generator seed 8'h01, 8 valid bits -> locked=1 on the following cycle, err_cnt=0; 200 further bits -> no err_pulse.
REQ-032 Single error: while locked, flip 1 bit -> err_pulse exactly once, err_cnt=1, locked stays 1, and following correct bits produce no errors.
REQ-033 Lost lock (defaults): 4 flipped bits within 16 -> locked=0 after the 4th, err_cnt=4; 8 further good bits -> relocked.
REQ-034 Zero guard: eight valid 0 bits -> locked stays 0, FSM back in HUNT; din_valid gaps of 3 cycles mid-LOAD -> lock timing counts only valid bits.
REQ-035 Counter edges: force err_cnt near 16'hFFFF with continuous errors (ERR_THRESH=WINDOW) -> holds at FFFF; clr_cnt coincident with an error -> err_cnt=0.
REQ-036 Async reset: pull rst_n low mid-clock while locked -> locked=0 and err_cnt=0 before the next edge.
